// File: rtl/mse_metric_acc_pkg.sv
// mse_metric_acc_pkg: shared types and width constants for the MSE metric accumulator.
//   Contents: state_t FSM encoding, default W/LOG2N, width helpers for the
//   squared error (SQ_W) and the SSE accumulator (ACC_W).
package mse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    localparam int W_DEF     = 16;
    localparam int LOG2N_DEF = 10;
    localparam int SQ_W      = 2 * W_DEF;
    localparam int ACC_W     = 2 * W_DEF + LOG2N_DEF;

    // Width helpers for non-default parameterisations.
    function automatic int sq_width(input int w);
        return 2 * w;
    endfunction

    // N squares of at most (2^W-1)^2 each cannot exceed 2*W+LOG2N bits.
    function automatic int acc_width(input int w, input int log2n);
        return 2 * w + log2n;
    endfunction

endpackage

// File: rtl/mse_metric_acc_if.sv
// mse_metric_acc_if: control, sample and result bundle of the MSE metric accumulator.
//   master (sample source): drives start, in_valid, y_ref, y_apx;
//                           sees busy, done, sse, mse, max_abs_err.
//   slave  (accumulator):   the reverse.
interface mse_metric_acc_if #(
    parameter int W     = mse_pkg::W_DEF,
    parameter int LOG2N = mse_pkg::LOG2N_DEF
);
    import mse_pkg::*;

    localparam int SQ_W_L  = sq_width(W);
    localparam int ACC_W_L = acc_width(W, LOG2N);

    logic               start;
    logic               in_valid;
    logic [W-1:0]       y_ref;
    logic [W-1:0]       y_apx;
    logic               busy;
    logic               done;
    logic [ACC_W_L-1:0] sse;
    logic [SQ_W_L-1:0]  mse;
    logic [W-1:0]       max_abs_err;

    modport master (
        output start, in_valid, y_ref, y_apx,
        input  busy, done, sse, mse, max_abs_err
    );

    modport slave (
        input  start, in_valid, y_ref, y_apx,
        output busy, done, sse, mse, max_abs_err
    );

endinterface

// File: rtl/mse_metric_acc_err_sq_pipe.sv
// err_sq_pipe: two-stage |y_ref - y_apx| and squared-error pipeline with valid tracking.
//   Inputs : clk, rstN (async, active-low), in_valid, y_ref/y_apx (W-bit signed).
//   Outputs: abs_err (stage-2 copy of |d|), sq (|d|^2, 2*W bits), out_valid (stage-2 valid).
module err_sq_pipe #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rstN,
    input  logic           in_valid,
    input  logic [W-1:0]   y_ref,
    input  logic [W-1:0]   y_apx,
    output logic [W-1:0]   abs_err,
    output logic [2*W-1:0] sq,
    output logic           out_valid
);

    localparam int SW = 2 * W;

    logic [W:0]    d;
    logic [W:0]    neg;
    logic [W-1:0]  abs_d;
    logic          v1_q;
    logic          v2_q;
    logic [W-1:0]  abs1_q;
    logic [W-1:0]  abs2_q;
    logic [SW-1:0] sq_q;

    // One extra bit keeps the difference exact; |d| <= 2^W-1 always fits W bits.
    assign d     = {y_ref[W-1], y_ref} - {y_apx[W-1], y_apx};
    assign neg   = -d;
    assign abs_d = d[W] ? neg[W-1:0] : d[W-1:0];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            abs1_q <= '0;
            abs2_q <= '0;
            sq_q   <= '0;
        end else begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            if (in_valid)
                abs1_q <= abs_d;
            if (v1_q) begin
                abs2_q <= abs1_q;
                sq_q   <= SW'(abs1_q) * SW'(abs1_q);
            end
        end
    end

    assign abs_err   = abs2_q;
    assign sq        = sq_q;
    assign out_valid = v2_q;

endmodule

// File: rtl/mse_metric_acc.sv
// mse_metric_acc: windowed SSE / MSE / peak-absolute-error meter for y_apx vs y_ref.
//   clk  : rising-edge clock
//   rstN : asynchronous active-low reset
//   bus  : mse_metric_acc_if.slave -- start/in_valid/y_ref/y_apx in,
//          busy/done/sse/mse/max_abs_err out
module mse_metric_acc
    import mse_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic clk,
    input  logic rstN,
    mse_metric_acc_if.slave bus
);

    localparam int SQ_W_L  = sq_width(W);
    localparam int ACC_W_L = acc_width(W, LOG2N);
    localparam int CW      = LOG2N + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << LOG2N) - 1);

    state_t              state_q, state_d;
    logic                take_start;
    logic                accept;
    logic                load;
    logic [CW-1:0]       cnt_q;
    logic                s1_q;
    logic [ACC_W_L-1:0]  acc_q;
    logic [ACC_W_L-1:0]  sse_q;
    logic [W-1:0]        max_q;
    logic [W-1:0]        max_abs_q;
    logic [W-1:0]        abs_err;
    logic [SQ_W_L-1:0]   sq;
    logic                sq_valid;

    err_sq_pipe #(.W(W)) u_pipe (
        .clk       (clk),
        .rstN      (rstN),
        .in_valid  (accept),
        .y_ref     (bus.y_ref),
        .y_apx     (bus.y_apx),
        .abs_err   (abs_err),
        .sq        (sq),
        .out_valid (sq_valid)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ACCUM;
            ACCUM:   if (accept && cnt_q == LAST) state_d = DRAIN;
            DRAIN:   if (!s1_q && !sq_valid) state_d = DONE;
            DONE:    state_d = bus.start ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        take_start = bus.start && (state_q == IDLE || state_q == DONE);
        accept     = bus.in_valid && state_q == ACCUM;
        load       = state_q == DRAIN && !s1_q && !sq_valid;
        bus.busy   = state_q == ACCUM || state_q == DRAIN;
        bus.done   = state_q == DONE;
    end

    // s1_q mirrors the pipeline's stage-1 valid so DRAIN can see both stages empty.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_q     <= '0;
            s1_q      <= 1'b0;
            acc_q     <= '0;
            max_q     <= '0;
            sse_q     <= '0;
            max_abs_q <= '0;
        end else begin
            s1_q <= accept;
            if (take_start) begin
                cnt_q <= '0;
                acc_q <= '0;
                max_q <= '0;
            end else begin
                if (accept)
                    cnt_q <= cnt_q + CW'(1);
                if (sq_valid) begin
                    acc_q <= acc_q + ACC_W_L'(sq);
                    if (abs_err > max_q)
                        max_q <= abs_err;
                end
            end
            if (load) begin
                sse_q     <= acc_q;
                max_abs_q <= max_q;
            end
        end
    end

    // Truncating divide by N is just dropping the low LOG2N bits.
    assign bus.sse         = sse_q;
    assign bus.mse         = sse_q[ACC_W_L-1:LOG2N];
    assign bus.max_abs_err = max_abs_q;

endmodule

// File: doc/mse_metric_acc.md
Name: mse_metric_acc

Overview:
- Downstream consumer of the FIR filter output in the MSE-metric flow.
- Compares the approximate-adder FIR output y_apx against the exact-adder FIR output y_ref, sample by sample, over a window of N = 2^LOG2N samples.
- Produces the sum of squared errors (SSE), the mean squared error (MSE = SSE >> LOG2N) and the peak absolute error.
- Its results are the quality metric reported for each approximate adder under test.

Parameters:
- W, 16, sample width (signed two's complement), matches the FIR output width.
- LOG2N, 10, log2 of the window length; N = 1024 samples.
- SQ_W, 2*W, width of one squared error (unsigned).
- ACC_W, 2*W+LOG2N, SSE accumulator width; cannot overflow by construction.

Ports:
- clk  in  1  rising-edge clock
- rstN  in  1  asynchronous active-low reset
- start  in  1  begin a new measurement window (pulse)
- in_valid  in  1  y_ref/y_apx pair valid this cycle
- y_ref  in  W  exact FIR output, signed
- y_apx  in  W  approximate FIR output, signed
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when results are final
- sse  out  ACC_W  sum of squared errors, unsigned
- mse  out  SQ_W  sse >> LOG2N, unsigned
- max_abs_err  out  W  largest |y_ref - y_apx| in the window, unsigned

Behaviour:
- Interface:
  - Single clock clk.
  - rstN is asynchronous, active-low.
  - Reset value of every register and output is zero: busy=0, done=0, sse=0, mse=0, max_abs_err=0, FSM=IDLE, pipeline valids=0.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
  - IDLE: start=1 -> clear accumulator, sample counter, max register and pipeline; go to ACCUM; busy=1 from the next cycle.
  - ACCUM: a sample is accepted on each edge with in_valid=1. The counter increments per accepted sample. When the Nth sample is accepted, go to DRAIN. in_valid=0 cycles are gaps: nothing is accepted and the counter holds.
  - DRAIN: no samples accepted. Wait until both pipeline stages are empty, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Pipeline, per accepted sample:
  - Stage 1: d = sign-extended y_ref - y_apx, W+1 bits, exact. Register |d| (fits W bits unsigned, max 65535) plus a valid bit.
  - Stage 2: sq = |d|*|d|, SQ_W bits unsigned (max 4294836225), registered with a valid bit.
  - Stage 3: acc += sq; max = (|d| > max) ? |d| : max. The max update is made from the stage-2 copy of |d|.
- Latency: done rises 3 clock edges after the edge that accepted the Nth sample, with back-to-back valid input.
- Result outputs:
  - sse, mse and max_abs_err update only on entry to DONE.
  - They then hold until the next accepted start. Intermediate accumulation is not visible.
  - mse is a truncating shift, with no rounding.
- Boundary conditions:
  - start while busy (ACCUM/DRAIN) is ignored.
  - start in the same cycle as done is accepted (DONE -> ACCUM directly).
  - in_valid outside ACCUM is ignored.
  - The sample counter is LOG2N+1 bits wide; it never wraps within a window.
  - rstN low at any point, including mid-window, aborts immediately to IDLE with all outputs zero. No partial result is reported.
  - y_ref = y_apx always gives sse = 0 and max_abs_err = 0.

Decomposition:
- Package mse_pkg holds:
  - the state typedef (enum IDLE/ACCUM/DRAIN/DONE);
  - default W and LOG2N constants;
  - width helper constants SQ_W and ACC_W.
- Sub-module err_sq_pipe: the two-stage difference/abs/square pipeline with valid tracking. It has parameter W, inputs clk/rstN/in_valid/y_ref/y_apx, and outputs abs_err, sq, out_valid.
- The top level holds the FSM, counter, accumulator, max tracker and result registers.

Test Plan:
- Reset: hold rstN=0 with random inputs toggling -> busy=0, done=0, sse=0, mse=0, max_abs_err=0.
- LOG2N=2, identical inputs: start, then 4 valid samples with y_ref=y_apx=1234 -> done 3 edges after the 4th sample; sse=0, mse=0, max_abs_err=0.
- LOG2N=2, constant error: y_ref=100, y_apx=97 x4 -> sse=36, mse=9, max_abs_err=3.
- LOG2N=2, extremes: y_ref=32767, y_apx=-32768 x4 -> sse=17179344900, mse=4294836225, max_abs_err=65535, no overflow.
- LOG2N=2, gaps and stray start:
  - Stimulus: errors +1, -5, +2, 0 with in_valid=0 gaps between samples; start pulsed in the middle of the window.
  - Response: the mid-window start is ignored; sse=30, mse=7, max_abs_err=5. done fires once, and only after the 4th valid sample.
- Reset mid-window: rstN low after 2 of 4 samples -> IDLE, busy=0, no done, outputs zero. A new start then gives a clean result, with no leakage of the earlier samples.
